// File: rtl/canny_pkg.sv
// canny_pkg: shared types for the Canny edge pipeline stages.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable; this package has no ports.
package canny_pkg;

  // Default unsigned gradient-magnitude width used across the pipeline.
  localparam int MAG_W = 11;

  // Quantised gradient direction as produced by the Sobel/angle stage.
  typedef enum logic [1:0] {
    ANG_0   = 2'd0,
    ANG_45  = 2'd1,
    ANG_90  = 2'd2,
    ANG_135 = 2'd3
  } angle_t;

  // One pixel as carried through line buffers and the 3x3 window.
  typedef struct packed {
    logic [MAG_W-1:0] mag;
    angle_t           angle;
  } pix_t;

  // Non-maximum test: the centre survives when it is not smaller than
  // either neighbour along its gradient direction (ties survive).
  function automatic logic nms_keep(
    input logic [MAG_W-1:0] centre,
    input logic [MAG_W-1:0] nb_a,
    input logic [MAG_W-1:0] nb_b
  );
    return (centre >= nb_a) && (centre >= nb_b);
  endfunction

endpackage

// File: rtl/nms_line_buffer.sv
// nms_line_buffer: one image row of {mag, angle}, read and written at the same index.
// Latency: combinational read of the old entry; the write lands on the rising edge.
// Backpressure: none; the owner only asserts i_we on an accepted input pixel.
// Ports: clk, i_we (write enable), i_idx (column), i_wdat (new entry), o_rdat (old entry).
module nms_line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  pix_t             i_wdat,
  output pix_t             o_rdat
);

  // Contents are never reset: every entry is rewritten during rows 0 and 1
  // of a frame, before any output depends on it.
  pix_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdat;
    end
  end

  // Read-before-write at the same index gives the pixel one row above.
  assign o_rdat = r_mem[i_idx];

endmodule

// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression over raster-order gradient pixels.
// Latency: one cycle from the input transfer that completes a window to out_valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready, no skid.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_mag/in_angle input stream;
//        out_valid/out_ready/out_mag/out_eof output stream (eof marks the last centre).
// MAG_W must match canny_pkg::MAG_W, since window and line-buffer storage use pix_t.
module nms_stream
  import canny_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int MAG_W = canny_pkg::MAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [1:0]       in_angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_eof
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Window indexed [line][column]: line 0 is the oldest row, column 2 the newest.
  pix_t r_win [3][3];

  logic             r_out_vld;
  logic [MAG_W-1:0] r_out_mag;
  logic             r_out_eof;

  logic             w_xfer;
  logic             w_trig;
  logic             w_last_pix;
  pix_t             w_in_pix;
  pix_t             w_lb0_rd;
  pix_t             w_lb1_rd;
  pix_t             w_win_nxt [3][3];
  pix_t             w_ctr;
  logic [MAG_W-1:0] w_nb_a;
  logic [MAG_W-1:0] w_nb_b;
  logic             w_keep;

  assign in_ready  = !r_out_vld || out_ready;
  assign w_xfer    = in_valid && in_ready;

  // A window is complete once two full columns and two full rows precede it,
  // so border centres are never produced.
  assign w_trig     = w_xfer && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_comb begin
    w_in_pix       = '0;
    w_in_pix.mag   = in_mag;
    w_in_pix.angle = angle_t'(in_angle);
  end

  // lb0 holds the previous row, lb1 the row before that; lb1 is refilled
  // from whatever lb0 is about to drop.
  nms_line_buffer #(
    .DEPTH (IMG_W),
    .IDX_W (COL_W)
  ) u_lb0 (
    .clk    (clk),
    .i_we   (w_xfer),
    .i_idx  (r_col),
    .i_wdat (w_in_pix),
    .o_rdat (w_lb0_rd)
  );

  nms_line_buffer #(
    .DEPTH (IMG_W),
    .IDX_W (COL_W)
  ) u_lb1 (
    .clk    (clk),
    .i_we   (w_xfer),
    .i_idx  (r_col),
    .i_wdat (w_lb0_rd),
    .o_rdat (w_lb1_rd)
  );

  // Window as it will look after this transfer; suppression is evaluated on
  // it directly so the result can be registered in the same cycle.
  for (genvar gi = 0; gi < 3; gi++) begin : g_shift
    assign w_win_nxt[gi][0] = r_win[gi][1];
    assign w_win_nxt[gi][1] = r_win[gi][2];
  end
  assign w_win_nxt[0][2] = w_lb1_rd;
  assign w_win_nxt[1][2] = w_lb0_rd;
  assign w_win_nxt[2][2] = w_in_pix;

  assign w_ctr = w_win_nxt[1][1];

  // Neighbour pair along the centre's gradient direction.
  always_comb begin
    w_nb_a = w_win_nxt[1][0].mag;
    w_nb_b = w_win_nxt[1][2].mag;
    case (w_ctr.angle)
      ANG_45: begin
        w_nb_a = w_win_nxt[0][2].mag;
        w_nb_b = w_win_nxt[2][0].mag;
      end
      ANG_90: begin
        w_nb_a = w_win_nxt[0][1].mag;
        w_nb_b = w_win_nxt[2][1].mag;
      end
      ANG_135: begin
        w_nb_a = w_win_nxt[0][0].mag;
        w_nb_b = w_win_nxt[2][2].mag;
      end
      default: begin
        w_nb_a = w_win_nxt[1][0].mag;
        w_nb_b = w_win_nxt[1][2].mag;
      end
    endcase
  end

  assign w_keep = nms_keep(w_ctr.mag, w_nb_a, w_nb_b);

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // The window keeps shifting across row boundaries; stale columns from the
  // previous row are flushed before any centre that uses them is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '{default: '0};
    end else if (w_xfer) begin
      r_win <= w_win_nxt;
    end
  end

  // A trigger can only occur when in_ready is high, so a stalled output is
  // never overwritten and holds stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_mag <= '0;
      r_out_eof <= 1'b0;
    end else if (w_trig) begin
      r_out_vld <= 1'b1;
      r_out_mag <= w_keep ? w_ctr.mag : '0;
      r_out_eof <= w_last_pix;
    end else if (out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_valid = r_out_vld;
  assign out_mag   = r_out_mag;
  assign out_eof   = r_out_eof;

endmodule

// File: tb/tb_nms_stream.sv
`timescale 1ns/1ps
module tb_nms_stream;

  localparam int MW = 11;
  localparam int BW = 64;
  localparam int BH = 48;
  localparam int SW = 4;
  localparam int SH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;  // 0: small 4x3 instance, 1: default 64x48 instance

  logic          drv_valid  = 1'b0;
  logic          drv_oready = 1'b1;
  logic [MW-1:0] drv_mag    = '0;
  logic [1:0]    drv_angle  = '0;

  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_eof;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_eof;
  logic [MW-1:0] s_out_mag, b_out_mag;

  assign s_in_valid  = drv_valid & ~sel;
  assign b_in_valid  = drv_valid & sel;
  assign s_out_ready = sel ? 1'b1 : drv_oready;
  assign b_out_ready = sel ? drv_oready : 1'b1;

  logic          in_ready_m, out_valid_m, out_eof_m;
  logic [MW-1:0] out_mag_m;
  assign in_ready_m  = sel ? b_in_ready  : s_in_ready;
  assign out_valid_m = sel ? b_out_valid : s_out_valid;
  assign out_eof_m   = sel ? b_out_eof   : s_out_eof;
  assign out_mag_m   = sel ? b_out_mag   : s_out_mag;

  nms_stream #(.IMG_W(SW), .IMG_H(SH), .MAG_W(MW)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mag(drv_mag), .in_angle(drv_angle),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_mag(s_out_mag), .out_eof(s_out_eof)
  );

  nms_stream u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mag(drv_mag), .in_angle(drv_angle),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mag(b_out_mag), .out_eof(b_out_eof)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame being streamed, and the scoreboard of expected {eof, mag}.
  int            fm [BH][BW];
  logic [1:0]    fa [BH][BW];
  logic [MW:0]   expq [$];
  logic          mv;          // expected out_valid
  int            mr, mc;      // raster position of next pixel to send
  int            eofs;
  int            frame_cnt;
  int            stall_cnt;
  bit            stall_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] nms_ref(input int r, input int c);
    int cm, a, b;
    cm = fm[r][c];
    case (fa[r][c])
      2'd0:    begin a = fm[r][c-1];   b = fm[r][c+1];   end
      2'd1:    begin a = fm[r-1][c+1]; b = fm[r+1][c-1]; end
      2'd2:    begin a = fm[r-1][c];   b = fm[r+1][c];   end
      default: begin a = fm[r-1][c-1]; b = fm[r+1][c+1]; end
    endcase
    return (cm >= a && cm >= b) ? MW'(cm) : '0;
  endfunction

  task automatic clear_frame(input int m, input int a);
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) begin
        fm[r][c] = m;
        fa[r][c] = 2'(a);
      end
  endtask

  task automatic rand_frame(input int maxv);
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) begin
        fm[r][c] = int'($urandom_range(maxv));
        fa[r][c] = 2'($urandom_range(3));
      end
  endtask

  // One clock cycle: drive at the falling edge, check and score 1ns later.
  task automatic step(input bit v, input bit rdy, output bit acc);
    int          w, h;
    bit          ordy, trig;
    logic [MW:0] e;
    w = sel ? BW : SW;
    h = sel ? BH : SH;
    @(negedge clk);
    ordy = rdy;
    if (stall_cnt > 0) begin
      ordy = 1'b0;
      stall_cnt--;
    end
    drv_valid  = v;
    drv_oready = ordy;
    drv_mag    = MW'(fm[mr][mc]);
    drv_angle  = fa[mr][mc];
    #1;
    check("in_ready", in_ready_m, !mv || ordy);
    check("out_valid", out_valid_m, mv);
    if (mv) begin
      if (expq.size() == 0) begin
        check("unexpected_output", expq.size(), 1);
      end else begin
        e = expq[0];
        check("out_mag", out_mag_m, e[MW-1:0]);
        check("out_eof", out_eof_m, e[MW]);
        if (ordy) begin
          e = expq.pop_front();
          frame_cnt++;
          if (e[MW]) begin
            eofs++;
            check("frame_out_count", frame_cnt, (h-2)*(w-2));
            frame_cnt = 0;
          end
        end
      end
    end
    acc  = v && in_ready_m;
    trig = 1'b0;
    if (acc) begin
      if (mr >= 2 && mc >= 2) begin
        e = {(mr == h-1 && mc == w-1), nms_ref(mr-1, mc-1)};
        expq.push_back(e);
        trig = 1'b1;
        if (stall_req) begin
          stall_cnt = 5;
          stall_req = 1'b0;
        end
      end
      if (mc == w-1) begin
        mc = 0;
        mr = (mr == h-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    mv = trig ? 1'b1 : (mv && !ordy);
  endtask

  task automatic send_pixels(input int npix, input int vpct, input int rpct);
    int sent, cyc, budget;
    bit acc, v, r;
    sent = 0; cyc = 0; budget = npix*20 + 50;
    while (sent < npix && cyc < budget) begin
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      step(v, r, acc);
      if (acc) sent++;
      cyc++;
    end
    check("pixels_accepted", sent, npix);
  endtask

  task automatic drain_check(input int exp_eofs);
    int cyc;
    bit acc;
    cyc = 0;
    while ((mv || expq.size() != 0) && cyc < 50) begin
      step(1'b0, 1'b1, acc);
      cyc++;
    end
    step(1'b0, 1'b1, acc);
    check("queue_left", expq.size(), 0);
    check("eof_count", eofs, exp_eofs);
    eofs = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3;
    drv_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_out_valid", out_valid_m, 1'b0);
    check("rst_out_eof", out_eof_m, 1'b0);
    check("rst_out_mag", out_mag_m, '0);
    check("rst_in_ready", in_ready_m, 1'b1);
    expq.delete();
    mv = 1'b0; mr = 0; mc = 0; frame_cnt = 0; eofs = 0; stall_cnt = 0;
    #8;
    rst_n = 1'b1;
  endtask

  task automatic set_sel(input logic s);
    sel = s;
    mv = 1'b0; mr = 0; mc = 0; frame_cnt = 0; eofs = 0;
    expq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    mv = 1'b0; mr = 0; mc = 0; eofs = 0; frame_cnt = 0; stall_cnt = 0; stall_req = 1'b0;
    clear_frame(0, 0);

    // Reset state, observed while reset is held.
    #12;
    check("reset_s_out_valid", s_out_valid, 1'b0);
    check("reset_s_out_mag", s_out_mag, '0);
    check("reset_s_out_eof", s_out_eof, 1'b0);
    check("reset_s_in_ready", s_in_ready, 1'b1);
    check("reset_b_out_valid", b_out_valid, 1'b0);
    check("reset_b_in_ready", b_in_ready, 1'b1);
    #11;
    rst_n = 1'b1;

    // 4x3 flat frame: two outputs of 5, eof on the second.
    set_sel(1'b0);
    clear_frame(5, 0);
    send_pixels(SW*SH, 100, 100);
    drain_check(1);

    // Vertical gradient: taller north neighbour suppresses, equal one keeps.
    clear_frame(0, 0);
    fm[1][1] = 10; fa[1][1] = 2'd2; fm[0][1] = 12; fm[2][1] = 3;
    send_pixels(SW*SH, 100, 100);
    drain_check(1);
    fm[0][1] = 10;
    send_pixels(SW*SH, 100, 100);
    drain_check(1);

    // Diagonals: NE=20 suppresses a 45-degree centre but not a 135-degree one.
    clear_frame(0, 0);
    fm[1][1] = 15; fa[1][1] = 2'd1; fm[0][2] = 20;
    send_pixels(SW*SH, 100, 100);
    drain_check(1);
    fa[1][1] = 2'd3;
    send_pixels(SW*SH, 100, 100);
    drain_check(1);

    // Five-cycle output stall right after the first result.
    rand_frame(7);
    stall_req = 1'b1;
    send_pixels(SW*SH, 100, 100);
    drain_check(1);

    // Asynchronous reset while an eof result is stalled, then a clean frame.
    rand_frame(7);
    send_pixels(SW*SH, 100, 100);
    step(1'b0, 1'b0, acc);
    pulse_reset();
    rand_frame(15);
    send_pixels(SW*SH, 80, 80);
    drain_check(1);

    // Full-size instance: abort at (1,2), then two random frames with stalls.
    set_sel(1'b1);
    rand_frame(2047);
    send_pixels(BW + 3, 80, 80);
    pulse_reset();
    rand_frame(2047);
    send_pixels(BW*BH, 75, 75);
    rand_frame(7);
    send_pixels(BW*BH, 75, 75);
    drain_check(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nms_stream.md
NMS_STREAM -- requirements
Module: nms_stream

Interface
REQ-001 Parameter IMG_W, default 64: pixels per row (IMG_W >= 3).
REQ-002 Parameter IMG_H, default 48: rows per frame (IMG_H >= 3).
REQ-003 Parameter MAG_W, default 11: unsigned gradient-magnitude width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_mag/in_angle hold a valid pixel.
REQ-007 in_ready  output  1  block can accept a pixel this cycle.
REQ-008 in_mag  input  MAG_W  unsigned gradient magnitude, row-major raster order.
REQ-009 in_angle  input  2  quantised direction: 0=0deg, 1=45deg, 2=90deg, 3=135deg.
REQ-010 out_valid  output  1  out_mag holds a valid suppressed pixel.
REQ-011 out_ready  input  1  downstream accepts out_mag this cycle.
REQ-012 out_mag  output  MAG_W  centre magnitude after non-maximum suppression.
REQ-013 out_eof  output  1  qualifies last output pixel of a frame.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (single output register, no skid buffer).
REQ-016 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on input transfer; col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame).
REQ-017 Two line buffers, each IMG_W entries of {mag, angle}, hold rows row-1 and row-2; written at index col on input transfer.
REQ-018 A 3x3 window of {mag, angle} shifts on each input transfer; the window is not cleared at row boundaries.
REQ-019 When the transfer is pixel (r,c) with r >= 2 and c >= 2, the centre pixel is (r-1,c-1); exactly (IMG_H-2)*(IMG_W-2) outputs per frame; no border pixels are emitted.
REQ-020 Neighbour pair by centre angle: 0 -> (r,c-1),(r,c+1) relative to centre; 1 -> (r-1,c+1),(r+1,c-1); 2 -> (r-1,c),(r+1,c); 3 -> (r-1,c-1),(r+1,c+1).
REQ-021 out_mag = centre mag if centre mag >= both neighbours (unsigned compare, ties kept), else 0.
REQ-022 Latency: out_valid is asserted the cycle after the triggering input transfer; out_mag and out_eof are registered with it.
REQ-023 out_valid, out_mag and out_eof SHALL hold stable while out_valid && !out_ready.
REQ-024 out_valid deasserts after an output transfer unless a new triggering input transfer occurs in the same cycle (back-to-back throughput of 1 pixel/cycle).
REQ-025 out_eof = 1 only for centre (IMG_H-2, IMG_W-2).
REQ-026 Non-triggering input transfers (r < 2 or c < 2) update buffers and counters only; out_valid is not set by them.

Reset
REQ-027 rst_n low asynchronously clears out_valid, out_mag, out_eof, col, row and the window to 0.
REQ-028 Line-buffer contents are not reset; they are overwritten before use.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first transfer after reset is pixel (0,0).
REQ-030 in_ready = 1 during and immediately after reset.

Structure
REQ-031 Shared package canny_pkg SHALL hold MAG_W default, the angle typedef (ANG_0, ANG_45, ANG_90, ANG_135) and the pixel struct {mag, angle}.
REQ-032 One sub-module, nms_line_buffer (IMG_W-deep, one read/one write per cycle, same index), instantiated twice.
REQ-033 Comparison/suppression logic SHALL be combinational inside nms_stream, feeding the output register.

Verification
REQ-034 IMG_W=4, IMG_H=3, all mag=5, angle=0, continuous valid, out_ready=1 -> 2 outputs, both 5 (ties kept), eof on the second.
REQ-035 Centre mag=10 angle=2, N=12, S=3 -> out_mag=0; same with N=10 -> out_mag=10.
REQ-036 Centre angle=1, NE=20, all else 0, centre=15 -> 0; centre angle=3 same window -> 15.
REQ-037 out_ready=0 for 5 cycles while output pending -> in_ready=0, out_mag stable, no input lost; resume yields original sequence.
REQ-038 rst_n pulsed low asynchronously mid-frame (row 1, col 2) -> out_valid=0 immediately; next frame's outputs match golden model from pixel (0,0).
REQ-039 Two consecutive 64x48 random frames with random in_valid/out_ready stalls -> output count 62*46 per frame, values match software NMS model, eof exactly once per frame.
